spi_serf: RTL and testbench

Responder end of the 16-bit SPI link driven by the flight controller's SPI monarch. Sits in the sensor/peripheral model or companion device on the same system clock. It oversamples SS_n/SCLK/MOSI, shifts 16 bits in on SCLK rising edges while returning a preloaded 16-bit word on MISO, then flags a completed or malformed frame when SS_n deasserts. Bus format: SCLK idles high, MSB first, one 16-bit word per SS_n-low window, monarch samples MISO just after each SCLK rise.

---
 rtl/spi_serf.sv | 110 +++++++++++
 tb/tb_spi_serf.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/spi_serf.sv
// SPI responder for the 16-bit monarch link: oversamples SS_n/SCLK/MOSI, shifts
// MSB-first on SCLK rises, returns a preloaded word on MISO, flags good/bad frames.
module spi_serf (
  input  logic        clk,
  input  logic        rst,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] tx_data,
  output logic [15:0] rx_data,
  output logic        rdy,
  output logic        err,
  output logic        busy
);

  typedef enum logic {IDLE, SHIFT} state_e;

  // Bit 0 is ff1, bit 1 is ff2, bit 2 is ff3.
  logic [2:0]  ss_ff_q,   ss_ff_d;
  logic [2:0]  sclk_ff_q, sclk_ff_d;
  logic [2:0]  mosi_ff_q, mosi_ff_d;
  state_e      state_q,   state_d;
  logic [15:0] shft_q,    shft_d;
  logic [4:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] rx_q,      rx_d;
  logic        rdy_q,     rdy_d;
  logic        err_q,     err_d;
  logic        busy_q,    busy_d;

  logic ss_fall, ss_rise, sclk_rise;

  always_comb begin
    ss_ff_d   = {ss_ff_q[1:0],   SS_n};
    sclk_ff_d = {sclk_ff_q[1:0], SCLK};
    mosi_ff_d = {mosi_ff_q[1:0], MOSI};
  end

  assign ss_fall   = ~ss_ff_q[1] &  ss_ff_q[2];
  assign ss_rise   =  ss_ff_q[1] & ~ss_ff_q[2];
  assign sclk_rise =  sclk_ff_q[1] & ~sclk_ff_q[2];

  always_comb begin
    // NOTE: every _d gets a default first so no branch can leave it unassigned
    // and infer a latch; the pulses default low so they last exactly one clock.
    state_d   = state_q;
    shft_d    = shft_q;
    bit_cnt_d = bit_cnt_q;
    rx_d      = rx_q;
    rdy_d     = 1'b0;
    err_d     = 1'b0;

    if (ss_fall) begin
      // Also covers an SS_n glitch mid-frame: reload and restart the count.
      state_d   = SHIFT;
      shft_d    = tx_data;
      bit_cnt_d = 5'd0;
    end else if (ss_rise) begin
      if (state_q == SHIFT) begin
        state_d = IDLE;
        if (bit_cnt_q == 5'd16) begin
          rx_d  = shft_q;
          rdy_d = 1'b1;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (sclk_rise && state_q == SHIFT) begin
      shft_d = {shft_q[14:0], mosi_ff_q[2]};
      if (bit_cnt_q != 5'd31) bit_cnt_d = bit_cnt_q + 5'd1;
    end

    busy_d = (state_d == SHIFT);
  end

  // NOTE: sequential state uses non-blocking assignments only, so every flop
  // samples the pre-edge value of its neighbours regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_ff_q   <= 3'b111;
      sclk_ff_q <= 3'b111;
      mosi_ff_q <= 3'b000;
      state_q   <= IDLE;
      shft_q    <= 16'h0000;
      bit_cnt_q <= 5'd0;
      rx_q      <= 16'h0000;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      ss_ff_q   <= ss_ff_d;
      sclk_ff_q <= sclk_ff_d;
      mosi_ff_q <= mosi_ff_d;
      state_q   <= state_d;
      shft_q    <= shft_d;
      bit_cnt_q <= bit_cnt_d;
      rx_q      <= rx_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign MISO    = shft_q[15];
  assign rx_data = rx_q;
  assign rdy     = rdy_q;
  assign err     = err_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_spi_serf.sv
// Directed bench for spi_serf: a behavioural SPI monarch drives frames and the
// bench checks returned MISO words, rx_data and rdy/err pulse counts.
module tb_spi_serf;

  logic        clk = 1'b0;
  logic        rst;
  logic        SS_n, SCLK, MOSI;
  logic        MISO;
  logic [15:0] tx_data;
  logic [15:0] rx_data;
  logic        rdy, err, busy;

  int tests = 0;
  int fails = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;
  logic [15:0] rdy_log[$];

  spi_serf dut (
    .clk     (clk),
    .rst     (rst),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO),
    .tx_data (tx_data),
    .rx_data (rx_data),
    .rdy     (rdy),
    .err     (err),
    .busy    (busy)
  );

  always #10 clk = ~clk;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (rdy) begin
      rdy_cnt++;
      rdy_log.push_back(rx_data);
    end
    if (err) err_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Sends n bits of w starting at bit index top, MSB first; MISO is sampled
  // one clock after each SCLK rise, ahead of the responder's shift.
  task automatic send_bits(input logic [15:0] w, input int top, input int n,
                           output logic [15:0] rd);
    rd = 16'h0000;
    for (int i = 0; i < n; i++) begin
      SCLK = 1'b0;
      MOSI = (top - i >= 0) ? w[top - i] : 1'b0;
      clks(4);
      SCLK = 1'b1;
      clks(1);
      rd = {rd[14:0], MISO};
      clks(3);
    end
  endtask

  task automatic frame(input logic [15:0] w, input int nrise, input int gap,
                       output logic [15:0] rd);
    SS_n = 1'b0;
    clks(12);
    send_bits(w, 15, nrise, rd);
    clks(4);
    SS_n = 1'b1;
    clks(gap);
  endtask

  logic [15:0] rd, rd1;
  int r0, e0;

  initial begin
    rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0; tx_data = 16'h0000;
    clks(5);
    rst = 1'b0;

    // Idle after reset: all outputs quiet for 50 clocks.
    for (int i = 0; i < 50; i++) begin
      check("idle_outputs", {12'h0, MISO, rdy, err, busy, rx_data}, 32'h0);
      clks(1);
    end

    // Basic frame.
    tx_data = 16'h3C5A;
    r0 = rdy_cnt; e0 = err_cnt;
    SS_n = 1'b0;
    clks(12);
    check("busy_in_frame", 32'(busy), 32'd1);
    send_bits(16'hA5C3, 15, 16, rd);
    clks(4);
    SS_n = 1'b1;
    clks(10);
    check("f1_miso_word", 32'(rd), 32'h3C5A);
    check("f1_rx_data", 32'(rx_data), 32'hA5C3);
    check("f1_rdy_pulses", 32'(rdy_cnt - r0), 32'd1);
    check("f1_err_pulses", 32'(err_cnt - e0), 32'd0);
    check("f1_busy_after", 32'(busy), 32'd0);

    // Back-to-back frames with a 4-clock SS_n high gap.
    r0 = rdy_cnt; e0 = err_cnt;
    rdy_log.delete();
    frame(16'h1234, 16, 0, rd1);
    SS_n = 1'b1;
    tx_data = 16'h0F0F;
    clks(4);
    frame(16'hFEDC, 16, 10, rd);
    check("b2b_miso_word1", 32'(rd1), 32'h3C5A);
    check("b2b_miso_word2", 32'(rd), 32'h0F0F);
    check("b2b_rdy_pulses", 32'(rdy_cnt - r0), 32'd2);
    check("b2b_err_pulses", 32'(err_cnt - e0), 32'd0);
    check("b2b_rx_first", 32'((rdy_log.size() > 0) ? rdy_log[0] : 16'hxxxx), 32'h1234);
    check("b2b_rx_data", 32'(rx_data), 32'hFEDC);

    // Short frame: 9 rises.
    r0 = rdy_cnt; e0 = err_cnt;
    frame(16'h5555, 9, 10, rd);
    check("short_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("short_rdy_pulses", 32'(rdy_cnt - r0), 32'd0);
    check("short_rx_kept", 32'(rx_data), 32'hFEDC);

    // Long frame: 17 rises.
    r0 = rdy_cnt; e0 = err_cnt;
    frame(16'hAAAA, 17, 10, rd);
    check("long_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("long_rdy_pulses", 32'(rdy_cnt - r0), 32'd0);
    check("long_rx_kept", 32'(rx_data), 32'hFEDC);

    // SS_n pulse with no clocks.
    e0 = err_cnt;
    frame(16'h0000, 0, 10, rd);
    check("zero_rise_err", 32'(err_cnt - e0), 32'd1);

    // Reset after 8 rises of BEEF, released with SS_n still low.
    r0 = rdy_cnt; e0 = err_cnt;
    SS_n = 1'b0;
    clks(12);
    send_bits(16'hBEEF, 15, 8, rd);
    rst = 1'b1;
    clks(2);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rx_cleared", 32'(rx_data), 32'h0000);
    rst = 1'b0;
    clks(12);
    check("rst_refall_busy", 32'(busy), 32'd1);
    send_bits(16'hBEEF, 7, 8, rd);
    clks(4);
    SS_n = 1'b1;
    clks(10);
    check("rst_err_pulses", 32'(err_cnt - e0), 32'd1);
    check("rst_rdy_pulses", 32'(rdy_cnt - r0), 32'd0);

    r0 = rdy_cnt; e0 = err_cnt;
    tx_data = 16'h8001;
    frame(16'h0001, 16, 10, rd);
    check("post_rst_miso", 32'(rd), 32'h8001);
    check("post_rst_rdy", 32'(rdy_cnt - r0), 32'd1);
    check("post_rst_err", 32'(err_cnt - e0), 32'd0);
    check("post_rst_rx", 32'(rx_data), 32'h0001);

    // SCLK activity while idle must not shift or pulse.
    r0 = rdy_cnt; e0 = err_cnt;
    send_bits(16'hFFFF, 15, 16, rd);
    clks(10);
    check("idle_sclk_miso", 32'(MISO), 32'd0);
    check("idle_sclk_rx", 32'(rx_data), 32'h0001);
    check("idle_sclk_busy", 32'(busy), 32'd0);
    check("idle_sclk_pulses", 32'((rdy_cnt - r0) + (err_cnt - e0)), 32'd0);

    // A normal frame afterwards shows bit_cnt was untouched by idle clocks.
    r0 = rdy_cnt; e0 = err_cnt;
    tx_data = 16'hC0DE;
    frame(16'h7E81, 16, 10, rd);
    check("final_miso", 32'(rd), 32'hC0DE);
    check("final_rx", 32'(rx_data), 32'h7E81);
    check("final_rdy", 32'(rdy_cnt - r0), 32'd1);
    check("final_err", 32'(err_cnt - e0), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
